// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - fetch-to-sequencer instruction byte handshake
interface alu_sequencer_if;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;

    modport master (output instr_valid, output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle sequencer driving an 8-bit ALU from a 4x8 register file
// Optional zero_flag output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_sequencer #(
    parameter int         NREGS   = 4,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        bus,
    output logic [7:0]            o_alu_a,
    output logic [7:0]            o_alu_b,
    output logic [3:0]            o_alu_op,
    input  logic [7:0]            i_alu_sum,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic                  o_illegal,
    input  logic [1:0]            i_dbg_sel,
    output logic [7:0]            o_dbg_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                  o_zero_flag
`endif
);
    typedef enum logic [2:0] {
        S_IDLE, S_IMM, S_READ, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     r_state;
    logic [3:0] r_op;
    logic [1:0] r_rd;
    logic [1:0] r_rs;
    logic [7:0] r_imm;
    logic [7:0] r_res;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_op;
    logic       r_busy;
    logic       r_halted;
    logic       r_illegal;
    logic [7:0] r_regs [NREGS];

    logic [3:0] w_op;
    logic       w_op_alu;

    assign w_op     = bus.instr_data[7:4];
    assign w_op_alu = (w_op >= 4'h1) && (w_op <= 4'h7);

    // Ready depends only on state so fetch can never see a combinational loop.
    assign bus.instr_ready = (r_state == S_IDLE) || (r_state == S_IMM);

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_busy     = r_busy;
    assign o_halted   = r_halted;
    assign o_illegal  = r_illegal;
    assign o_dbg_data = r_regs[i_dbg_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_rd      <= 2'd0;
            r_rs      <= 2'd0;
            r_imm     <= 8'h00;
            r_res     <= 8'h00;
            r_alu_a   <= 8'h00;
            r_alu_b   <= 8'h00;
            r_alu_op  <= 4'h0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_op <= w_op;
                        r_rd <= bus.instr_data[3:2];
                        r_rs <= bus.instr_data[1:0];
                        if (w_op_alu) begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                        end else if (w_op == OP_LDI) begin
                            r_state <= S_IMM;
                            r_busy  <= 1'b1;
                        end else if (w_op == OP_HALT) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else if (w_op != OP_NOP) begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    if (bus.instr_valid) begin
                        r_imm   <= bus.instr_data;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_alu_a  <= r_regs[r_rd];
                    r_alu_b  <= (r_op == OP_LDI) ? r_imm : r_regs[r_rs];
                    r_alu_op <= r_op;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_res    <= i_alu_sum;
                    r_alu_op <= 4'h0;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_regs[r_rd] <= r_res;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic r_zero_flag;

    assign o_zero_flag = r_zero_flag;

    // Only the write-back of an ALU op or LDI touches the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero_flag <= 1'b0;
        end else if (r_state == S_WB) begin
            r_zero_flag <= (r_res == 8'h00);
        end
    end
`endif
endmodule
